// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped UART transmitter (8N1, optional even parity).
//
// Sits on the data-memory port next to the data BRAM. Bytes written to TXDATA
// are queued in a FIFO and serialised LSB first on tx_o. Reads return STATUS
// with one-cycle registered latency, like the BRAM.
//
// Register map (addr[3:2]):
//   0x0 TXDATA  W: we_i[0] pushes di_i[7:0]        R: 0
//   0x4 STATUS  R: {16'h0, count[7:0], 4'h0, overflow, busy, empty, full}
//               W: we_i[0] && di_i[3] clears overflow
//   0x8, 0xC    R: 0, writes ignored
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous active-high reset
//   we_i    byte write enables
//   addr_i  byte address
//   di_i    write data
//   do_o    registered read data (0 outside the window)
//   tx_o    registered serial output, idles high
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (11 bit-times per frame instead of 10).

module mmio_uart_tx #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] di_i,
   output logic [31:0] do_o,
   output logic        tx_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH);
   localparam int TMR_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] PTR_ONE  = CNT_W'(1);
   localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W + 1)'(1);
   localparam logic [CNT_W:0]   CNT_FULL = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`endif

   // Registers
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W:0]   count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [2:0]       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       data_q, data_d;
   logic             tx_q, tx_d;
   logic [31:0]      do_q, do_d;

   // Combinational signals
   logic        hit_s, push_req_s, push_s, pop_s, clr_ovf_s;
   logic        full_s, empty_s, busy_s, bit_end_s;
   logic [31:0] count_ext_s;
   logic [31:0] status_s;
   logic        unused_s;

   assign hit_s       = (addr_i[31:4] == BASE_ADDR[31:4]);
   assign full_s      = (count_q == CNT_FULL);
   assign empty_s     = (count_q == {(CNT_W + 1){1'b0}});
   assign busy_s      = (state_q != S_IDLE);
   assign bit_end_s   = (timer_q == TMR_MAX);
   assign push_req_s  = hit_s && (addr_i[3:2] == 2'd0) && we_i[0];
   // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
   assign push_s      = push_req_s && !full_s;
   assign clr_ovf_s   = hit_s && (addr_i[3:2] == 2'd1) && we_i[0] && di_i[3];
   assign count_ext_s = 32'(count_q);
   assign status_s    = {16'h0000, count_ext_s[7:0], 4'h0, ovf_q, busy_s, empty_s, full_s};
   assign unused_s    = ^{we_i[3:1], addr_i[1:0], di_i[31:8], count_ext_s[31:8]};

   assign do_o = do_q;
   assign tx_o = tx_q;

   // Transmit FSM, FIFO bookkeeping and read mux next-state logic
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      data_d    = data_q;
      pop_s     = 1'b0;

      if (state_q == S_IDLE) begin
         timer_d = {TMR_W{1'b0}};
      end else if (bit_end_s) begin
         timer_d = {TMR_W{1'b0}};
      end else begin
         timer_d = timer_q + TMR_ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               state_d   = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end else if (bit_end_s) begin
               bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end_s) begin
               state_d = S_STOP;
            end else begin
               state_d = S_PARITY;
            end
         end
`endif
         S_STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (bit_end_s && !empty_s) begin
               pop_s   = 1'b1;
               data_d  = mem_q[rd_ptr_q];
               state_d = S_START;
            end else if (bit_end_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // tx is decoded from the next state so the registered pin lines up with it.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = even_parity(data_d);
`endif
         default:  tx_d = 1'b1;
      endcase

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A dropped push in the same cycle as a clear leaves overflow set.
      if (push_req_s && full_s) begin
         ovf_d = 1'b1;
      end else if (clr_ovf_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (hit_s && (addr_i[3:2] == 2'd1)) begin
         do_d = status_s;
      end else begin
         do_d = 32'h0000_0000;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= di_i[7:0];
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= {CNT_W{1'b0}};
         rd_ptr_q  <= {CNT_W{1'b0}};
         count_q   <= {(CNT_W + 1){1'b0}};
         ovf_q     <= 1'b0;
         state_q   <= S_IDLE;
         timer_q   <= {TMR_W{1'b0}};
         bit_idx_q <= 3'd0;
         data_q    <= 8'h00;
         tx_q      <= 1'b1;
         do_q      <= 32'h0000_0000;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
         do_q      <= do_d;
      end
   end

endmodule
